// File: rtl/mux8_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux8_reg
// Purpose  : 2:1 word select with a zero-latency output and a registered,
//            enable-gated output.
// Revision : 1.0
// ============================================================================
module mux8_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q
);

   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] r_y_q;

   // Per-bit conditional: an unknown select resolves to the operand bit when
   // both operands agree, and to x otherwise.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_y[i] = s ? b[i] : a[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_q <= RST_VAL;
      end else if (en) begin
         r_y_q <= w_y;
      end
   end

   assign y   = w_y;
   assign y_q = r_y_q;

endmodule
`default_nettype wire

// File: tb/tb_mux8_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_reg
// Purpose  : Self-checking bench for mux8_reg (vector table plus scoreboard).
// Revision : 1.0
// ============================================================================
module tb_mux8_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b;
   logic       s, en;
   logic [7:0] y, y_q;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_q;
   logic [7:0] sb_q[$];

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vs;
      logic [7:0] vy;
   } vec_t;

   vec_t vecs[8];

   mux8_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .s    (s),
      .en   (en),
      .y    (y),
      .y_q  (y_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   // Drive one cycle: check y immediately, queue the expected y_q, then
   // compare it just after the next rising edge.
   task automatic step(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                       input logic ie, input logic [7:0] ey, input string nm);
      logic [7:0] exp_q;
      a = ia; b = ib; s = is; en = ie;
      #1;
      check({nm, "_y"}, y, ey);
      exp_q   = ie ? ey : model_q;
      model_q = exp_q;
      sb_q.push_back(exp_q);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s_yq scoreboard empty", nm);
      end else begin
         check({nm, "_yq"}, y_q, sb_q.pop_front());
      end
   endtask

   initial begin
      vecs[0] = '{8'b11110000, 8'b00001111, 1'b0, 8'b11110000};
      vecs[1] = '{8'b11110000, 8'b00001111, 1'b1, 8'b00001111};
      vecs[2] = '{8'b10000000, 8'b00000001, 1'b1, 8'b00000001};
      vecs[3] = '{8'b10000000, 8'b00000001, 1'b0, 8'b10000000};
      vecs[4] = '{8'hA5,       8'hA5,       1'b1, 8'hA5};
      vecs[5] = '{8'hFF,       8'h00,       1'b1, 8'h00};
      vecs[6] = '{8'hFF,       8'h00,       1'b0, 8'hFF};
      vecs[7] = '{8'h5A,       8'hC3,       1'b0, 8'h5A};

      // Reset held while the clock runs, enable high
      rst_n = 1'b0; a = 8'hF0; b = 8'h0F; s = 1'b0; en = 1'b1;
      model_q = 8'h00;
      #1;
      check("rst_async", y_q, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_hold", y_q, 8'h00);
      end
      check("rst_y_unaffected", y, 8'hF0);
      rst_n = 1'b1;

      step(8'hF0, 8'h0F, 1'b0, 1'b1, 8'hF0, "first_load");

      foreach (vecs[i])
         step(vecs[i].va, vecs[i].vb, vecs[i].vs, 1'b1, vecs[i].vy, $sformatf("vec%0d", i));

      // Unknown select: agreement rule; enable low so nothing is captured
      a = 8'hA5; b = 8'hA5; s = 1'bx; en = 1'b0;
      #1;
      check("sx_agree_y", y, 8'hA5);
      a = 8'bxxxxxxxx; b = 8'bxxxxxxxx;
      #1;
      check("sx_allx_y", y, a);
      @(posedge clk); #1;
      check("sx_hold_yq", y_q, model_q);

      // y_q trails y by a cycle, then freezes with en=0
      for (int i = 0; i < 4; i++)
         step(8'h3C, 8'hC3, 1'(i % 2), 1'b1, (i % 2) ? 8'hC3 : 8'h3C, $sformatf("tog%0d", i));
      for (int i = 0; i < 3; i++)
         step(8'h3C, 8'hC3, 1'(i % 2), 1'b0, (i % 2) ? 8'hC3 : 8'h3C, $sformatf("frz%0d", i));
      check("frozen_c3", y_q, 8'hC3);

      // Reset asserted between edges clears y_q at once; y unaffected
      a = 8'h3C; b = 8'hC3; s = 1'b1; en = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_yq", y_q, 8'h00);
      check("midrst_y", y, 8'hC3);
      // Reset still low at the edge with en=1: reset wins
      @(posedge clk); #1;
      check("rst_wins_edge", y_q, 8'h00);
      rst_n = 1'b1;
      model_q = 8'h00;
      step(8'hF0, 8'h0F, 1'b0, 1'b1, 8'hF0, "post_rst_load");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux8_reg.md
Name: mux8_reg

Overview:
- Parameterised 2:1 word multiplexer, default 8 bits wide. Selects operand a (s=0) or b (s=1).
- Provides the selected word two ways: combinationally on y, and through an output register on y_q (one cycle later, with enable).
- Used as a datapath select stage wherever either a zero-latency or a pipelined select is needed.

Parameters:
- WIDTH, 8: data width of a, b, y, y_q.
- RST_VAL, 0: value loaded into y_q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock for the y_q register
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand selected when s=0
- b  input  WIDTH  operand selected when s=1
- s  input  1  select
- en  input  1  register load enable for y_q
- y  output  WIDTH  combinational mux result
- y_q  output  WIDTH  registered mux result

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is asynchronous and active-low (rst_n).
  - rst_n=0 forces y_q=RST_VAL immediately, independent of clk, and holds it while low.
  - Reset does not affect y.
- y (combinational, zero latency, no clock involvement):
  - s=0: y=a.
  - s=1: y=b.
  - Any change on a, b or s propagates to y in the same delta/time step.
- s unknown (x or z), 4-state simulation:
  - Each bit of y equals a[i] when a[i]==b[i] and both are known.
  - Otherwise that bit of y is x.
  - Consequence: a=b=all-x with s=x gives y=all-x.
  - Synthesis sees a plain 2:1 mux per bit.
- y_q (registered):
  - On a rising clk edge with rst_n=1 and en=1: y_q takes the value y had just before the edge. Latency is 1 cycle.
  - On a rising clk edge with en=0: y_q holds.
  - X on s or data when captured propagates into y_q per the y rule above.
- Reset mid-operation:
  - Asserting rst_n=0 between edges clears y_q at once.
  - On deassertion, the first rising edge with en=1 loads y.
- Simultaneous events:
  - Reset low at a clock edge: reset wins.
  - A change of s coincident with the clock edge: the pre-edge value is captured.
- Width rules:
  - No arithmetic.
  - All buses are exactly WIDTH bits; no truncation or extension.

Test Plan:
- a=8'b11110000, b=8'b00001111, s=0 -> y=8'b11110000. Then s=1 -> y=8'b00001111 in the same time step.
- With s=1, change a=8'b10000000, b=8'b00000001 -> y=8'b00000001. Then s=0 -> y=8'b10000000.
- a=b=8'bxxxxxxxx, s=x -> y=8'bxxxxxxxx. Also a=b=8'hA5, s=x -> y=8'hA5 (agreement rule).
- rst_n=0 while clk toggles, en=1 -> y_q=8'h00 throughout. Release, then a=8'hF0, s=0, one edge -> y_q=8'hF0.
- en=1, s toggles 0->1 each cycle with a=8'h3C, b=8'hC3 -> y_q trails y by one cycle. Then en=0 -> y_q frozen at last loaded value while y keeps switching.
- With y_q=8'hC3, assert rst_n=0 between clock edges -> y_q=8'h00 before the next edge; y unaffected.
